// File: rtl/kb_input_buffer.sv
// kb_input_buffer: PS/2 keyboard receiver feeding a show-ahead scan-code FIFO for the ALU keyboard port.
// Build option KB_BREAK_FILTER_EN: drop 8'hF0 break prefixes and the byte that follows them.
module kb_input_buffer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int KB_DATA_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          kb_pop,
    input  logic                          err_clr,
    output logic [KB_DATA_WIDTH-1:0]      kb_data,
    output logic                          kb_valid,
    output logic [$clog2(FIFO_DEPTH):0]   kb_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int BIT_CNT_W = (KB_DATA_WIDTH > 1) ? $clog2(KB_DATA_WIDTH) : 1;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(KB_DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]      TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_prev;
    logic r_data_s1;
    logic r_data_s2;
    logic w_fall;

    // NOTE: the clock chain resets to 1 (line idle level) so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b0;
            r_data_s2  <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t                  r_state;
    rx_state_t                  w_state_nxt;
    logic [BIT_CNT_W-1:0]       r_bit_cnt;
    logic [KB_DATA_WIDTH-1:0]   r_shift;
    logic                       r_parity;
    logic [TO_W-1:0]            r_to_cnt;
    logic                       w_timeout;
    logic                       w_stop_evt;
    logic                       w_frame_ok;
    logic                       w_good_byte;
    logic                       w_err_evt;
    logic                       w_push_req;

    // An edge arriving in the same cycle as the limit keeps the frame alive.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_data_s2) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == LAST_BIT) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stop_evt  = w_fall && (r_state == ST_STOP);
        w_frame_ok  = r_data_s2 && (^{r_shift, r_parity});
        w_good_byte = w_stop_evt && w_frame_ok;
        w_err_evt   = (w_stop_evt && !w_frame_ok) || w_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_timeout) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                end
                ST_DATA: begin
                    r_shift   <= {r_data_s2, r_shift[KB_DATA_WIDTH-1:1]};
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
                ST_PARITY: r_parity <= r_data_s2;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_fall || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

`ifdef KB_BREAK_FILTER_EN
    localparam logic [KB_DATA_WIDTH-1:0] BREAK_CODE = KB_DATA_WIDTH'(8'hF0);
    logic r_break_armed;

    // The armed flag swallows exactly one good byte, whatever its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_break_armed <= 1'b0;
        end else if (w_err_evt) begin
            r_break_armed <= 1'b0;
        end else if (w_good_byte) begin
            r_break_armed <= !r_break_armed && (r_shift == BREAK_CODE);
        end
    end

    assign w_push_req = w_good_byte && !r_break_armed && (r_shift != BREAK_CODE);
`else
    assign w_push_req = w_good_byte;
`endif

    logic                     r_push;
    logic [KB_DATA_WIDTH-1:0] r_push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= w_push_req;
            if (w_push_req) begin
                r_push_data <= r_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [KB_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W:0]          r_wr_ptr;
    logic [ADDR_W:0]          r_rd_ptr;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_do_pop;
    logic                     w_do_push;
    logic                     w_drop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_do_pop  = kb_pop && !w_empty;
    assign w_do_push = r_push && (!w_full || w_do_pop);
    assign w_drop    = r_push && w_full && !w_do_pop;

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= r_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
        end
    end

    assign kb_valid = !w_empty;
    assign kb_data  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign kb_count = r_wr_ptr - r_rd_ptr;

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle as err_clr wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (w_err_evt)     frame_err <= 1'b1;
            else if (err_clr)  frame_err <= 1'b0;
            if (w_drop)        overflow  <= 1'b1;
            else if (err_clr)  overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kb_input_buffer.sv
// Testbench for kb_input_buffer: 12 kHz PS/2 frames at a 1 MHz system clock, table-driven plus corner sequences.
// Expectations follow KB_BREAK_FILTER_EN when the same macro is defined for the bench.
`timescale 1ns/1ps
module tb_kb_input_buffer;

    localparam int HALF = 42;  // 42 clk cycles at 1 MHz per half PS/2 period (~12 kHz)

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       kb_pop;
    logic       err_clr;
    logic [7:0] kb_data;
    logic       kb_valid;
    logic [3:0] kb_count;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 0;
    int lat_use;

    kb_input_buffer #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (5000),
        .KB_DATA_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_pop    (kb_pop),
        .err_clr   (err_clr),
        .kb_data   (kb_data),
        .kb_valid  (kb_valid),
        .kb_count  (kb_count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    initial begin
        #(64'd200_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef enum {A_FRAME, A_BADPAR, A_BADSTOP, A_POP, A_CLR} act_e;
    typedef struct {
        act_e       act;
        logic [7:0] b;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [3:0] exp_count;
        logic       exp_ferr;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [7:0] d,
                              input logic [3:0] c, input logic fe, input logic ov);
        check({tag, ".kb_valid"},  kb_valid,  v);
        check({tag, ".kb_data"},   kb_data,   d);
        check({tag, ".kb_count"},  kb_count,  c);
        check({tag, ".frame_err"}, frame_err, fe);
        check({tag, ".overflow"},  overflow,  ov);
    endtask

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; pop_at>0 pulses kb_pop so it registers on that posedge after the stop edge.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                              input int pop_at, input bit measure);
        logic par;
        par = ~(^b) ^ flip_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = ~bad_stop;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            if (k == pop_at) kb_pop = 1'b1;
            @(posedge clk);
            #1;
            kb_pop = 1'b0;
            if (measure && lat == 0 && kb_valid) lat = k;
        end
        @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk);
        kb_pop = 1'b1;
        @(negedge clk);
        kb_pop = 1'b0;
    endtask

    task automatic clr1();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{A_FRAME,   8'h1C, 1'b1, 8'h1C, 4'd1, 1'b0, 1'b0};
        vecs[1]  = '{A_POP,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{A_BADPAR,  8'h1C, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
        vecs[3]  = '{A_CLR,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{A_BADSTOP, 8'h55, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
        vecs[5]  = '{A_CLR,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
`ifdef KB_BREAK_FILTER_EN
        vecs[6]  = '{A_FRAME,   8'hF0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{A_FRAME,   8'h1C, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{A_FRAME,   8'h32, 1'b1, 8'h32, 4'd1, 1'b0, 1'b0};
        vecs[9]  = '{A_POP,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{A_POP,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{A_POP,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
`else
        vecs[6]  = '{A_FRAME,   8'hF0, 1'b1, 8'hF0, 4'd1, 1'b0, 1'b0};
        vecs[7]  = '{A_FRAME,   8'h1C, 1'b1, 8'hF0, 4'd2, 1'b0, 1'b0};
        vecs[8]  = '{A_FRAME,   8'h32, 1'b1, 8'hF0, 4'd3, 1'b0, 1'b0};
        vecs[9]  = '{A_POP,     8'h00, 1'b1, 8'h1C, 4'd2, 1'b0, 1'b0};
        vecs[10] = '{A_POP,     8'h00, 1'b1, 8'h32, 4'd1, 1'b0, 1'b0};
        vecs[11] = '{A_POP,     8'h00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
`endif

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        kb_pop   = 1'b0;
        err_clr  = 1'b0;
        repeat (5) @(negedge clk);
        check_outs("reset_held", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_outs("reset_released", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        // First frame: latency from stop edge to kb_valid
        send_frame(8'h1C, 1'b0, 1'b0, 0, 1'b1);
        check("latency_in_1_to_5", (lat >= 1 && lat <= 5), 1);
        check_outs("first_frame", 1'b1, 8'h1C, 4'd1, 1'b0, 1'b0);
        pop1();
        check_outs("first_pop", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            case (vecs[i].act)
                A_FRAME:   send_frame(vecs[i].b, 1'b0, 1'b0, 0, 1'b0);
                A_BADPAR:  send_frame(vecs[i].b, 1'b1, 1'b0, 0, 1'b0);
                A_BADSTOP: send_frame(vecs[i].b, 1'b0, 1'b1, 0, 1'b0);
                A_POP:     pop1();
                A_CLR:     clr1();
                default:   ;
            endcase
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                       vecs[i].exp_count, vecs[i].exp_ferr, vecs[i].exp_ovf);
        end

        // Overflow: nine bytes into eight slots
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0, 1'b0);
        check_outs("ovf_full", 1'b1, 8'h01, 4'd8, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop_order%0d", i), kb_data, 8'(i));
            pop1();
        end
        check_outs("ovf_drained", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        clr1();
        check("ovf_clr", overflow, 1'b0);

        // Full FIFO with a pop on the same edge as a push
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 0, 1'b0);
        check("full_count", kb_count, 4'd8);
        lat_use = (lat >= 1 && lat <= 5) ? lat : 4;
        send_frame(8'h0A, 1'b0, 1'b0, lat_use, 1'b0);
        check_outs("full_pushpop", 1'b1, 8'h12, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_pop%0d", i), kb_data, (i < 7) ? 8'h12 + 8'(i) : 8'h0A);
            pop1();
        end
        check("full_drained", kb_count, 4'd0);

        // Timeout on a partial frame, then recovery
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (4000) @(negedge clk);
        check("timeout_not_early", frame_err, 1'b0);
        repeat (2000) @(negedge clk);
        check("timeout_ferr", frame_err, 1'b1);
        check("timeout_nothing_queued", kb_count, 4'd0);
        clr1();
        check("timeout_clr", frame_err, 1'b0);
        send_frame(8'h2A, 1'b0, 1'b0, 0, 1'b0);
        check_outs("after_timeout", 1'b1, 8'h2A, 4'd1, 1'b0, 1'b0);

        // Reset mid-frame empties the FIFO and aborts the frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outs("midframe_reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        send_frame(8'h4D, 1'b0, 1'b0, 0, 1'b0);
        check_outs("after_reset", 1'b1, 8'h4D, 4'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kb_input_buffer.md
# kb_input_buffer

PS/2 keyboard receiver and show-ahead byte FIFO feeding the ALU's `input_port_kb` operand. It deserialises PS/2 frames, checks parity and framing, and queues received scan codes. It presents the oldest byte to the execute stage, which pops it when an INKEY instruction retires from execute.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: number of queued bytes; must be a power of two and at least 2.
- `TIMEOUT_CYCLES`, 5000: system clocks without a PS/2 falling edge before a partial frame is abandoned.
- `KB_DATA_WIDTH`, 8: scan-code width; matches the ALU keyboard port width.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `ps2_clk`, in, 1: raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`, in, 1: raw PS/2 data line, asynchronous to `clk`.
- `kb_pop`, in, 1: asserted for one cycle by execute when an INKEY consumes the head byte.
- `err_clr`, in, 1: clears both sticky error flags.
- `kb_data`, out, 8: head byte of the FIFO; `8'h00` when empty. Drives ALU `input_port_kb`.
- `kb_valid`, out, 1: FIFO is not empty.
- `kb_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err`, out, 1: sticky flag for parity, stop-bit or timeout errors.
- `overflow`, out, 1: sticky flag set when a byte is dropped because the FIFO is full.

## Operation
- Input conditioning
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - A third register on the synchronised clock detects falling edges: previous value 1, current value 0.
  - Bits are sampled from synchronised data only on a detected falling edge.
- Receive FSM. States are IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), clear the bit counter and go to DATA. A falling edge with data=1 is ignored.
  - DATA: shift data in LSB first, 8 edges total, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP. The frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: on the edge, if data=1 and parity is good, issue a push. Otherwise set `frame_err` and push nothing. Return to IDLE in either case.
  - Timeout: in any state other than IDLE, a counter increments every cycle and resets on each falling edge. Reaching `TIMEOUT_CYCLES` sets `frame_err`, discards the partial byte and returns to IDLE.
- FIFO
  - Circular buffer with read and write pointers one bit wider than the address. Full and empty are derived from the pointers.
  - `kb_data` is a combinational read of `mem[rd_ptr]` (show-ahead), forced to 0 when empty.
  - Push while full with no pop in the same cycle: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect and occupancy is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect. The pop is ignored.
  - Pop while empty: ignored, no pointer movement.
- Sticky flags
  - `err_clr` clears both flags.
  - If a set event and `err_clr` occur in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE.
  - Pointers, counters and synchroniser flops are 0, except the synchronised `ps2_clk` chain, which resets to 1.
  - Outputs: `kb_valid`=0, `kb_data`=0, `kb_count`=0, `frame_err`=0, `overflow`=0.
  - FIFO contents are not reset.
- Latency: the stop-bit falling edge on the pins appears on `kb_valid`/`kb_data` at most 5 `clk` edges later. This is 2 sync + 1 edge detect + 1 push + 1 pointer update.
- A pop is registered at the `clk` edge where `kb_pop`=1. The next head byte is visible in the following cycle.
- `rst_n` asserted mid-frame immediately aborts the frame and empties the FIFO. No partial byte survives.
- `kb_count` tracks pointer state and updates on the same edge as the pointers.

## Configuration
- `KB_BREAK_FILTER_EN` defined:
  - A received `8'hF0` is not pushed and arms a one-shot drop flag.
  - The next good byte is also dropped, then the flag clears.
  - A frame error also clears the flag.
  - Result: only make codes reach the FIFO.
- `KB_BREAK_FILTER_EN` not defined: every good byte, including `8'hF0`, is pushed.

## Test plan
- Send frame 0x1C with correct odd parity at a 12 kHz PS/2 clock -> within 5 clocks of the stop edge, `kb_valid`=1, `kb_data`=0x1C, `kb_count`=1; pulse `kb_pop` -> `kb_valid`=0, `kb_data`=0x00.
- Send 0x1C with a flipped parity bit -> `frame_err`=1, `kb_count`=0; pulse `err_clr` -> `frame_err`=0.
- Send 9 good bytes 0x01..0x09 with no pops (FIFO_DEPTH=8) -> `kb_count`=8, `overflow`=1, pop order 0x01..0x08.
- With FIFO full, time a pop to coincide with a push of 0x0A -> `kb_count` stays 8 and the tail byte is 0x0A.
- Send start bit plus 3 data bits, then hold `ps2_clk` high for 6000 cycles -> `frame_err`=1 and FSM in IDLE; a following good frame 0x2A is then received correctly.
- Send 0xF0, 0x1C, 0x32 -> with `KB_BREAK_FILTER_EN` defined, only 0x32 is queued; without it, all three bytes are queued in order.
